// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, buffer entry layout, reset defaults.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with flush; head is read straight from the register array.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_mem    <= '{default: '0};
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory reader feeding an instruction buffer, with redirect/flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  input  logic        mem_valid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_redir_pc;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic [CW-1:0] w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;

  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_entry    = '{pc: r_pc, word: mem_rdata};
  assign w_pop      = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // The count check before ISSUE reserves the slot the response will land in,
  // since nothing else can push while this single read is outstanding.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          w_flush  = 1'b1;
        end else if (!mem_busy && (w_count < FULL)) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_flush     = 1'b1;
          w_state_nxt = S_DROP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_flush     = 1'b1;
          w_state_nxt = mem_valid ? S_IDLE : S_DROP;
        end else if (mem_valid) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          w_flush  = 1'b1;
        end
        if (mem_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_valid (instr_valid),
    .o_count (w_count)
  );

  assign instr     = w_head.word;
  assign instr_pc  = w_head.pc;
  assign mem_req   = (r_state == S_ISSUE);
  assign mem_addr  = r_pc;
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: latency-3 memory responder, expected-instruction queue, directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;
  logic        mem_valid = 1'b0;

  int total = 0;
  int bad = 0;
  int rx = 0;
  int overlap_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_busy       (mem_busy),
    .mem_valid      (mem_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * ((a >> 2) + 32'd1);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: not reset with the DUT, so an abandoned read still completes later.
  logic [1:0]  m_cnt = '0;
  logic [31:0] m_addr = '0;
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (m_cnt != 2'd0) begin
      m_cnt <= m_cnt - 2'd1;
      if (m_cnt == 2'd1) begin
        mem_valid <= 1'b1;
        mem_rdata <= word(m_addr);
        mem_busy  <= 1'b0;
      end
    end
    if (mem_req) begin
      req_log.push_back(mem_addr);
      if (m_cnt != 2'd0) overlap_err <= overlap_err + 1;
      else begin
        m_cnt    <= 2'd3;
        m_addr   <= mem_addr;
        mem_busy <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h expected nothing", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.w);
      end
      rx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!mem_req && n < 100);
    if (!mem_req) timeout(nm);
  endtask

  task automatic wait_mvalid(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!mem_valid && n < 100);
    if (!mem_valid) timeout(nm);
  endtask

  task automatic wait_rx(input int target, input string nm);
    int n = 0;
    while (rx < target && n < 200) begin tick(); n++; end
    if (rx < target) timeout(nm);
  endtask

  task automatic wait_log(input int target, input string nm);
    int n = 0;
    while (req_log.size() < target && n < 200) begin tick(); n++; end
    if (req_log.size() < target) timeout(nm);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 'x;
  endfunction

  task automatic do_reset(input logic do_redir, input logic [31:0] rpc);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    rst            = 1'b1;
    tick();
    tick();
    exp_q.delete();
    req_log.delete();
    rx  = 0;
    rst = 1'b0;
    if (do_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rpc;
      tick();
      redirect_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("mem_we", 32'(mem_we), 32'd0);
    chk("mem_wdata", mem_wdata, 32'h0);

    // Fill with downstream stalled, then drain and resume
    do_reset(1'b0, '0);
    repeat (40) tick();
    chk("stall_req_count", 32'(req_log.size()), 32'd4);
    chk("stall_last_addr", log_at(3), 32'h0000_000C);
    chk("stall_head_valid", 32'(instr_valid), 32'd1);
    exp_q.push_back('{32'h0, 32'h11});
    exp_q.push_back('{32'h4, 32'h22});
    exp_q.push_back('{32'h8, 32'h33});
    exp_q.push_back('{32'hC, 32'h44});
    instr_ready = 1'b1;
    wait_rx(4, "stream_rx");
    instr_ready = 1'b0;
    repeat (60) tick();
    chk("resume_addr", log_at(4), 32'h0000_0010);
    chk("refill_req_count", 32'(req_log.size()), 32'd8);
    chk("refill_last_addr", log_at(7), 32'h0000_001C);
    chk("refill_head_pc", instr_pc, 32'h0000_0010);
    chk("refill_head_instr", instr, 32'hA5A5_0010);

    // Redirect while a read is in flight
    do_reset(1'b0, '0);
    wait_req("b_req0");
    wait_req("b_req1");
    wait_req("b_req2");
    chk("b_pre_flush_valid", 32'(instr_valid), 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("b_flush_valid", 32'(instr_valid), 32'd0);
    wait_req("b_req_redir");
    chk("b_redir_addr", mem_addr, 32'h0000_0100);
    exp_q.push_back('{32'h100, 32'hA5A5_0100});
    instr_ready = 1'b1;
    wait_rx(1, "b_rx");
    instr_ready = 1'b0;

    // Redirect coincident with the read response
    do_reset(1'b0, '0);
    wait_req("c_req0");
    wait_mvalid("c_valid0");
    wait_req("c_req1");
    wait_mvalid("c_valid1");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("c_flush_valid", 32'(instr_valid), 32'd0);
    wait_req("c_req_redir");
    chk("c_redir_addr", mem_addr, 32'h0000_0200);
    exp_q.push_back('{32'h200, 32'hA5A5_0200});
    instr_ready = 1'b1;
    wait_rx(1, "c_rx");
    instr_ready = 1'b0;

    // Misaligned redirect target and PC wrap
    do_reset(1'b1, 32'h0000_0103);
    wait_req("d_req_align");
    chk("d_align_addr", mem_addr, 32'h0000_0100);
    do_reset(1'b1, 32'hFFFF_FFFC);
    wait_req("d_req_top");
    chk("d_top_addr", mem_addr, 32'hFFFF_FFFC);
    wait_req("d_req_wrap");
    chk("d_wrap_addr", mem_addr, 32'h0000_0000);
    exp_q.push_back('{32'hFFFF_FFFC, 32'h5A5A_FFFC});
    exp_q.push_back('{32'h0, 32'h11});
    instr_ready = 1'b1;
    wait_rx(2, "d_rx");
    instr_ready = 1'b0;

    // Reset during WAIT; the abandoned response must be ignored
    do_reset(1'b1, 32'h0000_0040);
    wait_req("e_req");
    chk("e_req_addr", mem_addr, 32'h0000_0040);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("e_stray_valid", 32'(instr_valid), 32'd0);
    end
    wait_log(2, "e_log");
    chk("e_restart_addr", log_at(1), 32'h0000_0000);
    exp_q.push_back('{32'h0, 32'h11});
    instr_ready = 1'b1;
    wait_rx(1, "e_rx");
    instr_ready = 1'b0;

    repeat (5) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("one_outstanding", 32'(overlap_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2), is the number of instruction buffer entries.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_valid  input  1  one-cycle request to change fetch PC (branch/jump).
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
REQ-007 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-008 instr_ready  input  1  downstream accepts the head this cycle.
REQ-009 instr  output  32  head instruction word.
REQ-010 instr_pc  output  32  address of the head instruction.
REQ-011 mem_req  output  1  one-cycle read request pulse to memory.
REQ-012 mem_we  output  1  tied 0.
REQ-013 mem_addr  output  32  read address, valid while mem_req=1.
REQ-014 mem_wdata  output  32  tied 0.
REQ-015 mem_rdata  input  32  read data, qualified by mem_valid.
REQ-016 mem_busy  input  1  memory transaction in progress.
REQ-017 mem_valid  input  1  one-cycle read-complete pulse.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DROP; at most one memory read is outstanding at any time.
REQ-019 IDLE->ISSUE when mem_busy=0, FIFO count < FIFO_DEPTH, and redirect_valid=0; otherwise stay in IDLE.
REQ-020 ISSUE drives mem_req=1 and mem_addr=fetch PC for exactly one cycle, then goes to WAIT; mem_req=0 in every other state.
REQ-021 WAIT on mem_valid: enqueue {fetch PC, mem_rdata}, fetch PC += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to IDLE.
REQ-022 Slot reservation: the count check at ISSUE guarantees a free entry when mem_valid arrives; an enqueue never occurs into a full FIFO.
REQ-023 redirect_valid in IDLE: fetch PC <= redirect_pc, FIFO flushed, stay in IDLE.
REQ-024 redirect_valid in ISSUE: fetch PC <= redirect_pc, FIFO flushed, go to DROP (request already issued).
REQ-025 redirect_valid in WAIT without mem_valid: fetch PC <= redirect_pc, flush, go to DROP.
REQ-026 redirect_valid in WAIT with mem_valid in the same cycle: response discarded, PC <= redirect_pc, flush, go to IDLE.
REQ-027 DROP discards the next mem_valid, then goes to IDLE; a redirect in DROP updates PC and flushes but stays in DROP.
REQ-028 mem_valid in IDLE or ISSUE is ignored (stale response).
REQ-029 The FIFO pops when instr_valid && instr_ready; pop and push in the same cycle leave the count unchanged.
REQ-030 Flush overrides a same-cycle pop and push; the FIFO is empty the following cycle.
REQ-031 instr_valid rises the cycle after the enqueuing mem_valid; instr and instr_pc are registered FIFO-head outputs.
REQ-032 Redirect changes instr_valid to 0 the following cycle; the first post-redirect fetch issues no earlier than two cycles after the redirect.

Reset
REQ-033 While rst=1, on each edge: state=IDLE, fetch PC=RESET_PC, FIFO empty, instr_valid=0, instr=0, instr_pc=0, mem_req=0.
REQ-034 A reset mid-transaction abandons the outstanding read; a later stray mem_valid is ignored per REQ-028.

Structure
REQ-035 The FSM state enum and the RESET_PC default belong in the shared CPU package (fetch_pkg).
REQ-036 The instruction buffer is a sub-module, fetch_fifo (parameterised width/depth, push/pop/flush, count output).

Verification
REQ-037 Reset, then connect memory with latency 3, words 0..3 = 0x11,0x22,0x33,0x44, instr_ready=1 -> instr/instr_pc stream (0x11,0),(0x22,4),(0x33,8),(0x44,12), one mem_req per fetch, never two outstanding.
REQ-038 instr_ready=0, FIFO_DEPTH=4 -> exactly 4 entries filled, then mem_req stays 0; raising instr_ready resumes issue at PC 0x10.
REQ-039 Redirect to 0x100 in the cycle after mem_req -> the in-flight response is dropped, the FIFO is empty, and the next mem_addr=0x100.
REQ-040 Redirect coincident with mem_valid -> no enqueue, and the next mem_addr is the redirect target.
REQ-041 Redirect to 0x103 -> mem_addr=0x100; fetch PC 0xFFFF_FFFC followed by a fetch -> next PC=0.
REQ-042 Assert rst while in WAIT, then inject mem_valid -> nothing enqueued, instr_valid=0, and the next mem_addr=RESET_PC.
